// File: rtl/alut_hdr_feeder_pkg.sv
// Shared constants for the ALUT header feeder: ALUT register map, command codes,
// flood mask and the sequencer state encoding.
package alut_feed_pkg;

   localparam int APB_AW = 7;
   localparam int APB_DW = 32;

   localparam logic [APB_AW-1:0] D_ADDR_LO = 7'h00;
   localparam logic [APB_AW-1:0] D_ADDR_HI = 7'h04;
   localparam logic [APB_AW-1:0] S_ADDR_LO = 7'h08;
   localparam logic [APB_AW-1:0] S_ADDR_HI = 7'h0C;
   localparam logic [APB_AW-1:0] S_PORT    = 7'h10;
   localparam logic [APB_AW-1:0] COMMAND   = 7'h14;
   localparam logic [APB_AW-1:0] STATUS    = 7'h18;
   localparam logic [APB_AW-1:0] D_PORT    = 7'h1C;

   localparam logic [1:0] CMD_CHECK  = 2'b01;
   localparam logic [4:0] FLOOD_MASK = 5'b0_1111;
   localparam logic [3:0] HDR_BYTES  = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_SETUP,
      ST_WR_ACCESS,
      ST_POLL_SETUP,
      ST_POLL_ACCESS,
      ST_RD_SETUP,
      ST_RD_ACCESS,
      ST_RESULT
   } feed_state_e;

   // Register written by each step of the lookup programming sequence.
   function automatic logic [APB_AW-1:0] wr_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    return D_ADDR_LO;
         3'd1:    return D_ADDR_HI;
         3'd2:    return S_ADDR_LO;
         3'd3:    return S_ADDR_HI;
         3'd4:    return S_PORT;
         default: return COMMAND;
      endcase
   endfunction

endpackage

// File: rtl/alut_hdr_feeder_if.sv
// APB link between the header feeder (master) and the ALUT register block (slave).
interface alut_hdr_feeder_if;
   import alut_feed_pkg::*;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [APB_AW-1:0] paddr;
   logic [APB_DW-1:0] pwdata;
   logic [APB_DW-1:0] prdata;

   modport master (output psel, output penable, output pwrite, output paddr, output pwdata,
                   input  prdata);
   modport slave  (input  psel, input  penable, input  pwrite, input  paddr, input  pwdata,
                   output prdata);
endinterface

// File: rtl/alut_hdr_feeder_apb.sv
// Single-transfer APB master: start launches SETUP then ACCESS (no wait states);
// done is high during ACCESS so the caller can chain the next transfer with a one-cycle gap.
module alut_apb_master
   import alut_feed_pkg::*;
(
   input  logic              pclk,
   input  logic              p_reset,
   input  logic              start,
   input  logic              write,
   input  logic [APB_AW-1:0] addr,
   input  logic [APB_DW-1:0] wdata,
   output logic              done,
   output logic [APB_DW-1:0] rdata,
   alut_hdr_feeder_if.master apb
);

   always_ff @(posedge pclk) begin
      if (p_reset) begin
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.paddr   <= '0;
         apb.pwdata  <= '0;
      end else if (apb.psel && apb.penable) begin
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
      end else if (apb.psel) begin
         apb.penable <= 1'b1;
      end else if (start) begin
         apb.psel    <= 1'b1;
         apb.pwrite  <= write;
         apb.paddr   <= addr;
         apb.pwdata  <= wdata;
      end
   end

   assign done  = apb.psel & apb.penable;
   assign rdata = apb.prdata;

endmodule

// File: rtl/alut_hdr_feeder.sv
// ALUT header feeder: captures DA/SA from the RX stream, runs the ALUT lookup over APB
// and offers the destination mask on a valid/ready port. Optional ALUT_FEED_STATS_EN adds counters.
module alut_hdr_feeder
   import alut_feed_pkg::*;
#(
   parameter int POLL_MAX = 64
`ifdef ALUT_FEED_STATS_EN
  ,parameter int CNT_W    = 16
`endif
) (
   input  logic       pclk,
   input  logic       p_reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_sof,
   input  logic       rx_eof,
   input  logic [1:0] rx_port,
   output logic       rx_ready,
   alut_hdr_feeder_if.master apb,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [4:0] res_dport,
   output logic       res_err
`ifdef ALUT_FEED_STATS_EN
  ,input  logic             stat_clr
  ,output logic [CNT_W-1:0] stat_lookups
  ,output logic [CNT_W-1:0] stat_drops
  ,output logic [CNT_W-1:0] stat_timeouts
`endif
);

   localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

   feed_state_e       state;
   logic [3:0]        byte_cnt;
   logic [3:0]        cap_idx;
   logic [47:0]       da;
   logic [47:0]       sa;
   logic [1:0]        port;
   logic [2:0]        wr_idx;
   logic [PCW-1:0]    poll_cnt;

   logic              apb_start;
   logic              apb_write;
   logic              apb_done;
   logic [APB_AW-1:0] apb_addr;
   logic [APB_DW-1:0] apb_wdata;
   logic [APB_DW-1:0] apb_rdata;
   logic              unused_rdata;

   logic              cap_en;
   logic              hdr_last;
   logic              short_drop;
   logic              poll_timeout;
   logic              res_take;

   function automatic logic [APB_DW-1:0] wr_data(input logic [2:0]  idx,
                                                 input logic [47:0] d,
                                                 input logic [47:0] s,
                                                 input logic [1:0]  p);
      case (idx)
         3'd0:    return d[31:0];
         3'd1:    return {16'h0, d[47:32]};
         3'd2:    return s[31:0];
         3'd3:    return {16'h0, s[47:32]};
         3'd4:    return {30'h0, p};
         default: return {30'h0, CMD_CHECK};
      endcase
   endfunction

   // A SOF byte always restarts the header, whatever the running count says.
   assign cap_en       = (state == ST_IDLE) && rx_valid;
   assign cap_idx      = rx_sof ? 4'd0 : byte_cnt;
   assign hdr_last     = cap_en && (cap_idx == 4'd11);
   assign short_drop   = cap_en && rx_eof && (cap_idx < 4'd11);
   assign poll_timeout = (state == ST_POLL_ACCESS) && apb_done && apb_rdata[0] &&
                         (poll_cnt == PCW'(POLL_MAX - 1));
   assign res_take     = (state == ST_RESULT) && res_ready;
   assign unused_rdata = ^apb_rdata[APB_DW-1:5];

   always_comb begin
      apb_start = 1'b0;
      apb_write = 1'b0;
      apb_addr  = '0;
      apb_wdata = '0;
      case (state)
         ST_WR_SETUP: begin
            apb_start = 1'b1;
            apb_write = 1'b1;
            apb_addr  = wr_addr(wr_idx);
            apb_wdata = wr_data(wr_idx, da, sa, port);
         end
         ST_POLL_SETUP: begin
            apb_start = 1'b1;
            apb_addr  = STATUS;
         end
         ST_RD_SETUP: begin
            apb_start = 1'b1;
            apb_addr  = D_PORT;
         end
         default: ;
      endcase
   end

   alut_apb_master u_apb (
      .pclk    (pclk),
      .p_reset (p_reset),
      .start   (apb_start),
      .write   (apb_write),
      .addr    (apb_addr),
      .wdata   (apb_wdata),
      .done    (apb_done),
      .rdata   (apb_rdata),
      .apb     (apb)
   );

   always_ff @(posedge pclk) begin
      if (cap_en) begin
         if (rx_sof) port <= rx_port;
         if (cap_idx < 4'd6)           da <= {da[39:0], rx_data};
         else if (cap_idx < HDR_BYTES) sa <= {sa[39:0], rx_data};
      end
   end

   always_ff @(posedge pclk) begin
      if (p_reset) begin
         state     <= ST_IDLE;
         rx_ready  <= 1'b1;
         byte_cnt  <= '0;
         wr_idx    <= '0;
         poll_cnt  <= '0;
         res_valid <= 1'b0;
         res_dport <= '0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (short_drop) begin
                  byte_cnt <= HDR_BYTES;
               end else if (hdr_last) begin
                  byte_cnt <= HDR_BYTES;
                  rx_ready <= 1'b0;
                  wr_idx   <= '0;
                  state    <= ST_WR_SETUP;
               end else if (cap_en && cap_idx < HDR_BYTES) begin
                  byte_cnt <= cap_idx + 4'd1;
               end
            end
            ST_WR_SETUP:  state <= ST_WR_ACCESS;
            ST_WR_ACCESS: begin
               if (apb_done) begin
                  if (wr_idx == 3'd5) begin
                     poll_cnt <= '0;
                     state    <= ST_POLL_SETUP;
                  end else begin
                     wr_idx <= wr_idx + 3'd1;
                     state  <= ST_WR_SETUP;
                  end
               end
            end
            ST_POLL_SETUP:  state <= ST_POLL_ACCESS;
            ST_POLL_ACCESS: begin
               if (poll_timeout) begin
                  res_valid <= 1'b1;
                  res_dport <= FLOOD_MASK;
                  res_err   <= 1'b1;
                  state     <= ST_RESULT;
               end else if (apb_done && apb_rdata[0]) begin
                  poll_cnt <= poll_cnt + PCW'(1);
                  state    <= ST_POLL_SETUP;
               end else if (apb_done) begin
                  state <= ST_RD_SETUP;
               end
            end
            ST_RD_SETUP:  state <= ST_RD_ACCESS;
            ST_RD_ACCESS: begin
               if (apb_done) begin
                  res_valid <= 1'b1;
                  res_dport <= apb_rdata[4:0];
                  res_err   <= 1'b0;
                  state     <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (res_take) begin
                  res_valid <= 1'b0;
                  rx_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALUT_FEED_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge pclk) begin
      if (p_reset || stat_clr) begin
         stat_lookups  <= '0;
         stat_drops    <= '0;
         stat_timeouts <= '0;
      end else begin
         if (res_take)     stat_lookups  <= sat_inc(stat_lookups);
         if (short_drop)   stat_drops    <= sat_inc(stat_drops);
         if (poll_timeout) stat_timeouts <= sat_inc(stat_timeouts);
      end
   end
`endif

endmodule

// File: tb/tb_alut_hdr_feeder.sv
// Directed bench for alut_hdr_feeder: table of lookup frames plus hand-written
// sequences for short frames and reset in the middle of an APB write.
`timescale 1ns/1ps
module tb_alut_hdr_feeder;

   localparam int LOGN = 512;

   typedef struct {
      logic [47:0] da;
      logic [47:0] sa;
      logic [1:0]  port;
      int          n_active;
      logic [4:0]  dport;
      logic [4:0]  exp_dport;
      logic        exp_err;
      int          exp_reads;
      int          exp_lat;
      int          hold;
   } frame_t;

   logic       pclk = 1'b0;
   logic       p_reset;
   logic [7:0] rx_data;
   logic       rx_valid, rx_sof, rx_eof;
   logic [1:0] rx_port;
   logic       rx_ready;
   logic       res_valid, res_ready, res_err;
   logic [4:0] res_dport;
`ifdef ALUT_FEED_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_lookups, stat_drops, stat_timeouts;
`endif

   alut_hdr_feeder_if apb_bus();

   alut_hdr_feeder #(.POLL_MAX(64)) dut (
      .pclk      (pclk),
      .p_reset   (p_reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_sof    (rx_sof),
      .rx_eof    (rx_eof),
      .rx_port   (rx_port),
      .rx_ready  (rx_ready),
      .apb       (apb_bus),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_dport (res_dport),
      .res_err   (res_err)
`ifdef ALUT_FEED_STATS_EN
     ,.stat_clr      (stat_clr)
     ,.stat_lookups  (stat_lookups)
     ,.stat_drops    (stat_drops)
     ,.stat_timeouts (stat_timeouts)
`endif
   );

   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;

   // ALUT slave model and transfer log
   int          n_active  = 0;
   logic [4:0]  dport_val = 5'h0;
   int          stat_base = 0;
   int          status_reads = 0;
   int          log_n = 0;
   logic        log_wr   [LOGN];
   logic [6:0]  log_addr [LOGN];
   logic [31:0] log_data [LOGN];

   always_comb begin
      apb_bus.prdata = 32'h0;
      if (apb_bus.paddr == 7'h18)
         apb_bus.prdata = {31'h7FFF_0000, ((status_reads - stat_base) < n_active)};
      else if (apb_bus.paddr == 7'h1C)
         apb_bus.prdata = {27'h1234567, dport_val};
   end

   always @(posedge pclk) begin
      if (!p_reset && apb_bus.psel && apb_bus.penable && log_n < LOGN) begin
         log_wr[log_n]   <= apb_bus.pwrite;
         log_addr[log_n] <= apb_bus.paddr;
         log_data[log_n] <= apb_bus.pwdata;
         log_n           <= log_n + 1;
         if (!apb_bus.pwrite && apb_bus.paddr == 7'h18) status_reads <= status_reads + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] exp_addr(input int k);
      case (k)
         0: return 7'h00;
         1: return 7'h04;
         2: return 7'h08;
         3: return 7'h0C;
         4: return 7'h10;
         default: return 7'h14;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input int k, input frame_t f);
      case (k)
         0: return f.da[31:0];
         1: return {16'h0, f.da[47:32]};
         2: return f.sa[31:0];
         3: return {16'h0, f.sa[47:32]};
         4: return {30'h0, f.port};
         default: return 32'h1;
      endcase
   endfunction

   // Drive nbytes header bytes of f, SOF on the first, EOF on the last.
   task automatic send_hdr(input frame_t f, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         rx_valid = 1'b1;
         rx_sof   = (i == 0);
         rx_eof   = (i == nbytes - 1);
         rx_port  = f.port;
         rx_data  = (i < 6) ? f.da[47 - 8*i -: 8] : f.sa[47 - 8*(i-6) -: 8];
         @(posedge pclk); #1;
      end
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
   endtask

   task automatic run_frame(input frame_t f, input string tag);
      int   base, lat, n_st, n_dp, n_exp;
      logic stable;
      base      = log_n;
      stat_base = status_reads;
      n_active  = f.n_active;
      dport_val = f.dport;
      send_hdr(f, 12);
      // cycle 1 is the cycle after the byte-11 capture edge
      lat = 0;
      for (int n = 1; n <= 400; n++) begin
         if (res_valid) begin
            lat = n;
            break;
         end
         @(posedge pclk); #1;
      end
      check({tag, " latency"}, lat, f.exp_lat);
      check({tag, " res_dport"}, res_dport, f.exp_dport);
      check({tag, " res_err"}, res_err, f.exp_err);
      check({tag, " rx_ready busy"}, rx_ready, 1'b0);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("%s wr%0d write", tag, k), log_wr[base+k], 1'b1);
         check($sformatf("%s wr%0d addr", tag, k), log_addr[base+k], exp_addr(k));
         check($sformatf("%s wr%0d data", tag, k), log_data[base+k], exp_wdata(k, f));
      end
      n_st = 0;
      n_dp = 0;
      for (int k = base + 6; k < log_n; k++) begin
         if (!log_wr[k] && log_addr[k] == 7'h18) n_st++;
         else if (!log_wr[k] && log_addr[k] == 7'h1C) n_dp++;
      end
      n_exp = 6 + f.exp_reads + (f.exp_err ? 0 : 1);
      check({tag, " status reads"}, n_st, f.exp_reads);
      check({tag, " dport reads"}, n_dp, f.exp_err ? 0 : 1);
      check({tag, " transfer count"}, log_n - base, n_exp);
      stable = 1'b1;
      for (int h = 0; h < f.hold; h++) begin
         @(posedge pclk); #1;
         stable &= (res_valid === 1'b1) && (res_dport === f.exp_dport) &&
                   (res_err === f.exp_err) && (rx_ready === 1'b0);
      end
      if (f.hold > 0) check({tag, " held stable"}, stable, 1'b1);
      res_ready = 1'b1;
      @(posedge pclk); #1;
      res_ready = 1'b0;
      check({tag, " res_valid after take"}, res_valid, 1'b0);
      check({tag, " rx_ready after take"}, rx_ready, 1'b1);
   endtask

   frame_t vec [4];
   frame_t f;
   int     base;
   logic   quiet, found;

   initial begin
      vec[0] = '{48'h0011_2233_4455, 48'h6677_8899_AABB, 2'd2, 0,    5'b0_0100, 5'b0_0100, 1'b0, 1,  25,  0};
      vec[1] = '{48'h0123_4567_89AB, 48'hFEDC_BA98_7654, 2'd1, 3,    5'b1_0001, 5'b1_0001, 1'b0, 4,  34,  0};
      vec[2] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 2'd3, 1000, 5'b0_0010, 5'b0_1111, 1'b1, 64, 211, 0};
      vec[3] = '{48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 2'd0, 0,    5'b1_0000, 5'b1_0000, 1'b0, 1,  25,  10};

      p_reset   = 1'b1;
      rx_data   = 8'h0;
      rx_valid  = 1'b0;
      rx_sof    = 1'b0;
      rx_eof    = 1'b0;
      rx_port   = 2'd0;
      res_ready = 1'b0;
`ifdef ALUT_FEED_STATS_EN
      stat_clr  = 1'b0;
`endif
      repeat (3) @(posedge pclk);
      #1;
      check("reset rx_ready", rx_ready, 1'b1);
      check("reset psel", apb_bus.psel, 1'b0);
      check("reset penable", apb_bus.penable, 1'b0);
      check("reset pwrite", apb_bus.pwrite, 1'b0);
      check("reset paddr", apb_bus.paddr, 7'h0);
      check("reset pwdata", apb_bus.pwdata, 32'h0);
      check("reset res_valid", res_valid, 1'b0);
      check("reset res_dport", res_dport, 5'h0);
      check("reset res_err", res_err, 1'b0);
      p_reset = 1'b0;
      @(posedge pclk); #1;

      for (int r = 0; r < 4; r++) run_frame(vec[r], $sformatf("vec%0d", r));

      // Frame ending at byte 7 is dropped without any ALUT traffic.
      base = log_n;
      send_hdr(vec[1], 8);
      quiet = 1'b1;
      for (int n = 0; n < 8; n++) begin
         quiet &= (rx_ready === 1'b1) && (apb_bus.psel === 1'b0);
         @(posedge pclk); #1;
      end
      check("short quiet", quiet, 1'b1);
      check("short no transfers", log_n - base, 0);
      run_frame(vec[0], "after_short");

      // Reset during the ACCESS phase of the fourth write.
      base = log_n;
      f = vec[1];
      send_hdr(f, 12);
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (apb_bus.psel && apb_bus.penable && apb_bus.paddr == 7'h0C) begin
            found = 1'b1;
            break;
         end
         @(posedge pclk); #1;
      end
      check("rst reached wr3", found, 1'b1);
      p_reset = 1'b1;
      @(posedge pclk); #1;
      check("rst psel", apb_bus.psel, 1'b0);
      check("rst penable", apb_bus.penable, 1'b0);
      check("rst pwrite", apb_bus.pwrite, 1'b0);
      check("rst paddr", apb_bus.paddr, 7'h0);
      check("rst pwdata", apb_bus.pwdata, 32'h0);
      check("rst rx_ready", rx_ready, 1'b1);
      check("rst res_valid", res_valid, 1'b0);
      check("rst transfers done", log_n - base, 3);
      p_reset = 1'b0;
      @(posedge pclk); #1;
      run_frame(vec[0], "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
